uart_bus_bridge: RTL and testbench
==================================

// Module: uart_bus_bridge
// PURPOSE
// - UART-driven bus initiator: the host-side counterpart to the core's memory-mapped UART.
// - Takes bytes from uart_rx and parses host commands. Issues word reads/writes on the data-memory
//   bus in place of the pipeline, then returns replies through uart_tx.
// - Used for program load and memory inspection. hold stalls the pipeline while a command executes.
// PARAMETERS
// - TIMEOUT_CYCLES  default 100_000  max clk cycles between bytes of one command; 0 = no timeout.
// PORTS
// - clk            in   1   system clock
// - rst            in   1   asynchronous reset, active-low (0 = reset)
// - rx_data        in   8   received byte from uart_rx
// - rx_data_valid  in   1   one-cycle strobe: rx_data is valid
// - tx_data        out  8   byte to send to uart_tx
// - tx_data_valid  out  1   tx_data valid; held until accepted
// - tx_ready       in   1   uart_tx can accept; transfer = tx_data_valid & tx_ready
// - bus_req        out  1   bus access request; held until bus_ready
// - bus_rw         out  1   1 = write, 0 = read; stable while bus_req
// - bus_addr       out  32  word address; [1:0] always 0
// - bus_wdata      out  32  write data
// - bus_rdata      in   32  read data; valid in the bus_ready cycle
// - bus_ready      in   1   completes the access; may be high in the same cycle bus_req rises
// - hold           out  1   pipeline stall; high from first opcode byte until last reply byte accepted
// - rx_drop        out  1   one-cycle pulse: rx byte discarded (arrived in BUS/RESP)
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters and shift registers cleared.
// - Reset mid-command: aborts at once; no bus access completes and no reply follows.
// - Protocol; multi-byte fields are little-endian:
//   - 'W' 0x57: 4 addr bytes + 4 data bytes -> one bus write -> reply 0x06.
//   - 'R' 0x52: 4 addr bytes -> one bus read -> reply 4 data bytes, LSB first.
//   - Any other opcode in IDLE -> reply 0x15 (NAK); stays in IDLE flow.
// - States: IDLE -> ADDR -> (DATA if 'W') -> [CSUM] -> BUS -> RESP -> IDLE.
//   - byte_cnt is 2 bits and wraps 3 -> 0 when leaving ADDR or DATA.
// - Address check: if addr[1:0] != 0 when ADDR completes, skip BUS and reply 0x15.
//   - For 'W' the data bytes are still consumed first.
// - Latency:
//   - bus_req rises the cycle after the final command byte's strobe.
//   - tx_data_valid rises the cycle after the bus_ready sample.
//   - Next reply byte is presented the cycle after each accepted transfer.
// - Read data is captured on bus_ready; later bus_rdata changes do not affect the reply.
// - bus_req drops the cycle after bus_ready; exactly one access per command.
// - hold rises the same cycle as the opcode strobe (combinational from rx_data_valid in IDLE).
//   - It falls the cycle after the final reply byte is accepted.
// - Timeout (ADDR/DATA/CSUM only):
//   - Gap counter clears on every rx strobe.
//   - Reaching TIMEOUT_CYCLES returns to IDLE silently: no reply, hold drops.
// - rx strobe during BUS or RESP: byte discarded, rx_drop pulses, state unaffected.
// - rx strobe in the same cycle as a timeout: the byte wins; the counter clears and no abort occurs.
// - tx_ready low indefinitely: stay in RESP with tx_data stable; no timeout in RESP.
// CONFIGURATION
// - UART_BUS_BRIDGE_CSUM_EN defined:
//   - Each command carries a trailing checksum byte = XOR of the opcode and all payload bytes.
//   - Mismatch -> no bus access; reply 0x15.
//   - A NAK for an unknown opcode is sent without waiting for a checksum.
// - Not defined: CSUM state is absent and commands end at the last payload byte.
// TESTING
// - 'W' 00 01 00 00 EF BE AD DE -> one bus write, addr 0x0000_0100, wdata 0xDEAD_BEEF, bus_rw=1; tx 0x06.
// - 'R' 00 01 00 00, bus_rdata=0x1234_5678 with bus_ready after 3 cycles -> tx 78 56 34 12; hold low afterwards.
// - 'W' 02 00 00 00 + 4 data bytes -> no bus_req; tx 0x15. Opcode 0x41 -> tx 0x15.
// - TIMEOUT_CYCLES=50, send 'R' 00 then wait 50 cycles -> IDLE, no tx, hold 0.
//   - A following valid 'R' is serviced normally.
// - tx_ready held low 20 cycles during a read reply -> tx_data stable throughout.
//   - Byte sent in RESP -> rx_drop pulse; reply unaffected.
// - Assert rst with bus_req high -> bus_req, hold, tx_data_valid 0 in the same cycle.
//   - CSUM_EN build: a bad checksum -> 0x15 with no bus_req.

Source files
------------

// File: rtl/uart_bus_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bus_bridge_if                                           |
// | Description : UART byte streams, data-memory bus and pipeline-hold signals |
// |               shared between the UART bus bridge and its environment.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface uart_bus_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_rw;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        hold;
    logic        rx_drop;

    modport master (
        input  rx_data, rx_data_valid, tx_ready, bus_rdata, bus_ready,
        output tx_data, tx_data_valid, bus_req, bus_rw, bus_addr, bus_wdata,
               hold, rx_drop
    );

    modport slave (
        output rx_data, rx_data_valid, tx_ready, bus_rdata, bus_ready,
        input  tx_data, tx_data_valid, bus_req, bus_rw, bus_addr, bus_wdata,
               hold, rx_drop
    );
endinterface
`default_nettype wire

// File: rtl/uart_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bus_bridge                                              |
// | Description : UART-driven bus initiator: parses 'W'/'R' host commands,     |
// |               performs one word access and replies over uart_tx.          |
// |               UART_BUS_BRIDGE_CSUM_EN adds a trailing XOR checksum byte.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic              clk,
    input  logic              rst,
    uart_bus_bridge_if.master bus_if
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;
`ifdef UART_BUS_BRIDGE_CSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd5;
`endif

    localparam logic [7:0]  OP_WRITE = 8'h57;
    localparam logic [7:0]  OP_READ  = 8'h52;
    localparam logic [7:0]  ACK      = 8'h06;
    localparam logic [7:0]  NAK      = 8'h15;
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] reply_q, reply_d;
    logic [1:0]  rem_q, rem_d;
    logic        tx_valid_q, tx_valid_d;
    logic        bus_req_q, bus_req_d;
    logic        rx_drop_q, rx_drop_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
`ifdef UART_BUS_BRIDGE_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        w_rx_v;
    logic [7:0]  w_rx;
    logic        w_timed;
    logic        w_timeout;
    logic        w_launch;
    logic        w_nak;

    assign w_rx_v  = bus_if.rx_data_valid;
    assign w_rx    = bus_if.rx_data;
`ifdef UART_BUS_BRIDGE_CSUM_EN
    assign w_timed = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
    assign w_timed = (state_q == ST_ADDR) || (state_q == ST_DATA);
`endif
    assign w_timeout = w_timed && (TIMEOUT_CYCLES != 0) && (gap_cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        reply_d    = reply_q;
        rem_d      = rem_q;
        tx_valid_d = tx_valid_q;
        bus_req_d  = bus_req_q;
        rx_drop_d  = 1'b0;
`ifdef UART_BUS_BRIDGE_CSUM_EN
        csum_d     = csum_q;
`endif
        w_launch   = 1'b0;
        w_nak      = 1'b0;
        // A strobe in the expiry cycle still clears the counter, so the byte wins.
        gap_cnt_d  = (w_timed && !w_rx_v && !w_timeout) ? gap_cnt_q + 32'd1 : 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (w_rx_v) begin
                    byte_cnt_d = 2'd0;
`ifdef UART_BUS_BRIDGE_CSUM_EN
                    csum_d     = w_rx;
`endif
                    if ((w_rx == OP_WRITE) || (w_rx == OP_READ)) begin
                        is_wr_d = (w_rx == OP_WRITE);
                        state_d = ST_ADDR;
                    end else begin
                        reply_d    = {24'h0, NAK};
                        rem_d      = 2'd0;
                        tx_valid_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (w_rx_v) begin
                    addr_d     = {w_rx, addr_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_BUS_BRIDGE_CSUM_EN
                    csum_d     = csum_q ^ w_rx;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = ST_DATA;
                        end else begin
`ifdef UART_BUS_BRIDGE_CSUM_EN
                            state_d = ST_CSUM;
`else
                            // Address byte 0 sits in [15:8] until this final shift.
                            w_launch = 1'b1;
                            w_nak    = (addr_q[9:8] != 2'b00);
`endif
                        end
                    end
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_rx_v) begin
                    wdata_d    = {w_rx, wdata_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UART_BUS_BRIDGE_CSUM_EN
                    csum_d     = csum_q ^ w_rx;
                    if (byte_cnt_q == 2'd3) state_d = ST_CSUM;
`else
                    if (byte_cnt_q == 2'd3) begin
                        w_launch = 1'b1;
                        w_nak    = (addr_q[1:0] != 2'b00);
                    end
`endif
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef UART_BUS_BRIDGE_CSUM_EN
            ST_CSUM: begin
                if (w_rx_v) begin
                    w_launch = 1'b1;
                    w_nak    = (addr_q[1:0] != 2'b00) || (w_rx != csum_q);
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_BUS: begin
                rx_drop_d = w_rx_v;
                if (bus_if.bus_ready) begin
                    bus_req_d  = 1'b0;
                    tx_valid_d = 1'b1;
                    state_d    = ST_RESP;
                    if (is_wr_q) begin
                        reply_d = {24'h0, ACK};
                        rem_d   = 2'd0;
                    end else begin
                        reply_d = bus_if.bus_rdata;
                        rem_d   = 2'd3;
                    end
                end
            end
            ST_RESP: begin
                rx_drop_d = w_rx_v;
                if (tx_valid_q && bus_if.tx_ready) begin
                    if (rem_q == 2'd0) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        reply_d = {8'h0, reply_q[31:8]};
                        rem_d   = rem_q - 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_launch) begin
            if (w_nak) begin
                reply_d    = {24'h0, NAK};
                rem_d      = 2'd0;
                tx_valid_d = 1'b1;
                state_d    = ST_RESP;
            end else begin
                bus_req_d = 1'b1;
                state_d   = ST_BUS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            byte_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            reply_q    <= 32'd0;
            rem_q      <= 2'd0;
            tx_valid_q <= 1'b0;
            bus_req_q  <= 1'b0;
            rx_drop_q  <= 1'b0;
            gap_cnt_q  <= 32'd0;
`ifdef UART_BUS_BRIDGE_CSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            reply_q    <= reply_d;
            rem_q      <= rem_d;
            tx_valid_q <= tx_valid_d;
            bus_req_q  <= bus_req_d;
            rx_drop_q  <= rx_drop_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef UART_BUS_BRIDGE_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus_if.tx_data       = reply_q[7:0];
    assign bus_if.tx_data_valid = tx_valid_q;
    assign bus_if.bus_req       = bus_req_q;
    assign bus_if.bus_rw        = is_wr_q;
    assign bus_if.bus_addr      = {addr_q[31:2], 2'b00};
    assign bus_if.bus_wdata     = wdata_q;
    assign bus_if.rx_drop       = rx_drop_q;
    // Stall starts on the opcode strobe itself, before any state has changed.
    assign bus_if.hold          = (state_q != ST_IDLE) || (w_rx_v && rst);

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_bus_bridge                                           |
// | Description : Scoreboard bench for uart_bus_bridge (directed commands).    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_uart_bus_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_bus_bridge_if bif ();

    uart_bus_bridge #(.TIMEOUT_CYCLES(50)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    bus_exp_t    exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          drop_cnt = 0;
    int          bus_cnt  = 0;
    int          bus_lat  = 0;
    logic        ready_always = 1'b0;
    logic [31:0] rdata_val = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_bus(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        bus_exp_t e;
        e.rw = rw; e.addr = addr; e.wdata = wdata;
        exp_bus.push_back(e);
    endtask

    task automatic expect_read(input logic [31:0] addr, input logic [31:0] data);
        expect_bus(1'b0, addr, 32'd0);
        for (int i = 0; i < 4; i++) exp_tx.push_back(data[8*i +: 8]);
    endtask

    // Scoreboard monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (bif.tx_data_valid && bif.tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected no reply", bif.tx_data);
                end else begin
                    check("tx_byte", 32'(bif.tx_data), 32'(exp_tx.pop_front()));
                end
            end
            if (bif.bus_req && bif.bus_ready) begin
                bus_cnt++;
                if (exp_bus.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL bus_unexpected: got access addr 0x%0h rw %0d, expected none",
                             bif.bus_addr, bif.bus_rw);
                end else begin
                    bus_exp_t e;
                    e = exp_bus.pop_front();
                    check("bus_rw", 32'(bif.bus_rw), 32'(e.rw));
                    check("bus_addr", bif.bus_addr, e.addr);
                    if (e.rw) check("bus_wdata", bif.bus_wdata, e.wdata);
                end
            end
            if (bif.rx_drop) drop_cnt++;
        end
    end

    // Bus responder: ready after bus_lat cycles, or permanently high.
    initial begin : responder
        int wcnt;
        wcnt = 0;
        bif.bus_ready = 1'b0;
        bif.bus_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (ready_always) begin
                bif.bus_ready = 1'b1; bif.bus_rdata = rdata_val; wcnt = 0;
            end else if (bif.bus_ready) begin
                bif.bus_ready = 1'b0; bif.bus_rdata = 32'hFFFF_FFFF;
            end else if (bif.bus_req) begin
                if (wcnt >= bus_lat) begin
                    bif.bus_ready = 1'b1; bif.bus_rdata = rdata_val; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bif.rx_data = b; bif.rx_data_valid = 1'b1;
        tick(1);
        bif.rx_data_valid = 1'b0;
    endtask

    task automatic send_opcode(input logic [7:0] op);
        bif.rx_data = op; bif.rx_data_valid = 1'b1;
        #1;
        check("hold_on_opcode", 32'(bif.hold), 32'd1);
        @(posedge clk); #1;
        bif.rx_data_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input int gap, input logic exp_req);
        logic [7:0] bytes[$];
        logic [7:0] x;
        for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
        if (op == 8'h57) for (int i = 0; i < 4; i++) bytes.push_back(data[8*i +: 8]);
        x = op;
        foreach (bytes[i]) x = x ^ bytes[i];
`ifdef UART_BUS_BRIDGE_CSUM_EN
        bytes.push_back(x);
`endif
        send_opcode(op);
        foreach (bytes[i]) begin
            tick(gap);
            send_byte(bytes[i]);
        end
        check("bus_req_latency", 32'(bif.bus_req), 32'(exp_req));
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_tx.size() != 0 || bif.hold) && k < 400) begin
            tick(1); k++;
        end
        check({name, "_hold"}, 32'(bif.hold), 32'd0);
        check({name, "_tx_left"}, exp_tx.size(), 32'd0);
        check({name, "_bus_left"}, exp_bus.size(), 32'd0);
        tick(2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int d;
        int k;
        bif.rx_data = 8'h00; bif.rx_data_valid = 1'b0; bif.tx_ready = 1'b1;
        tick(3);
        check("rst_tx_valid", 32'(bif.tx_data_valid), 32'd0);
        check("rst_bus_req", 32'(bif.bus_req), 32'd0);
        check("rst_hold", 32'(bif.hold), 32'd0);
        check("rst_rx_drop", 32'(bif.rx_drop), 32'd0);
        check("rst_bus_addr", bif.bus_addr, 32'd0);
        rst = 1'b1;
        tick(2);

        expect_bus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        exp_tx.push_back(8'h06);
        send_cmd(8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b1);
        wait_idle("write");

        bus_lat = 3; rdata_val = 32'h1234_5678;
        expect_read(32'h0000_0100, 32'h1234_5678);
        send_cmd(8'h52, 32'h0000_0100, 32'd0, 1, 1'b1);
        wait_idle("read");

        c = bus_cnt;
        exp_tx.push_back(8'h15);
        send_cmd(8'h57, 32'h0000_0002, 32'h1122_3344, 0, 1'b0);
        wait_idle("misaligned_write");
        exp_tx.push_back(8'h15);
        send_cmd(8'h52, 32'h0000_0103, 32'd0, 0, 1'b0);
        wait_idle("misaligned_read");
        exp_tx.push_back(8'h15);
        send_opcode(8'h41);
        wait_idle("unknown_op");
        check("nak_no_bus", bus_cnt, c);

        send_byte(8'h52);
        send_byte(8'h00);
        tick(60);
        check("timeout_hold", 32'(bif.hold), 32'd0);
        check("timeout_tx_valid", 32'(bif.tx_data_valid), 32'd0);
        check("timeout_no_bus", bus_cnt, c);

        ready_always = 1'b1; rdata_val = 32'hA5C3_0F96;
        expect_read(32'h0000_0200, 32'hA5C3_0F96);
        send_cmd(8'h52, 32'h0000_0200, 32'd0, 0, 1'b1);
        wait_idle("after_timeout");
        ready_always = 1'b0;
        tick(3);
        check("one_access", bus_cnt, c + 1);

        bus_lat = 0; rdata_val = 32'h0BAD_F00D;
        expect_read(32'h0000_03FC, 32'h0BAD_F00D);
        send_cmd(8'h52, 32'h0000_03FC, 32'd0, 45, 1'b1);
        wait_idle("slow_bytes");

        bif.tx_ready = 1'b0; bus_lat = 2; rdata_val = 32'h1234_5678;
        d = drop_cnt;
        expect_read(32'h0000_0100, 32'h1234_5678);
        send_cmd(8'h52, 32'h0000_0100, 32'd0, 0, 1'b1);
        k = 0;
        while (!bif.tx_data_valid && k < 50) begin tick(1); k++; end
        check("stall_valid", 32'(bif.tx_data_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("stall_tx_data", 32'(bif.tx_data), 32'h78);
            if (i == 5) send_byte(8'hAA);
            else tick(1);
        end
        check("rx_drop_pulse", drop_cnt, d + 1);
        bif.tx_ready = 1'b1;
        wait_idle("stall");

        bus_lat = 1000;
        send_cmd(8'h52, 32'h0000_0100, 32'd0, 0, 1'b1);
        tick(2);
        rst = 1'b0;
        #1;
        check("async_rst_bus_req", 32'(bif.bus_req), 32'd0);
        check("async_rst_hold", 32'(bif.hold), 32'd0);
        check("async_rst_tx_valid", 32'(bif.tx_data_valid), 32'd0);
        tick(2);
        rst = 1'b1;
        bus_lat = 0; rdata_val = 32'hCAFE_F00D;
        tick(3);
        expect_read(32'h0000_0040, 32'hCAFE_F00D);
        send_cmd(8'h52, 32'h0000_0040, 32'd0, 0, 1'b1);
        wait_idle("after_reset");

`ifdef UART_BUS_BRIDGE_CSUM_EN
        c = bus_cnt;
        exp_tx.push_back(8'h15);
        send_opcode(8'h57);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h00);
        check("bad_csum_no_req", 32'(bif.bus_req), 32'd0);
        wait_idle("bad_csum");
        check("bad_csum_no_bus", bus_cnt, c);
`endif

        tick(5);
        check("final_tx_queue", exp_tx.size(), 32'd0);
        check("final_bus_queue", exp_bus.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
